serial_subtractor_m_bits: RTL and testbench

SERIAL_SUBTRACTOR_M_BITS -- requirements
Module: serial_subtractor_m_bits

---
 rtl/serial_subtractor_m_bits_pkg.sv | 14 +
 rtl/Vr_HW2_FA.sv | 15 +
 rtl/serial_subtractor_m_bits.sv | 105 ++++++++++
 tb/tb_serial_subtractor_m_bits.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_m_bits_pkg.sv
// Shared definitions for the HW2 arithmetic blocks.
//   hw2_state_e   : common IDLE/RUN/FIN state encoding
//   HW2_DEFAULT_M : default operand width
package serial_subtractor_m_bits_pkg;

  localparam int unsigned HW2_DEFAULT_M = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } hw2_state_e;

endpackage

// File: rtl/Vr_HW2_FA.sv
// One-bit full adder.
//   A, B, CIN : addend bits and carry-in
//   S, COUT   : sum bit and carry-out
module Vr_HW2_FA (
  input  logic A,
  input  logic B,
  input  logic CIN,
  output logic S,
  output logic COUT
);

  assign S    = A ^ B ^ CIN;
  assign COUT = (A & B) | (A & CIN) | (B & CIN);

endmodule

// File: rtl/serial_subtractor_m_bits.sv
// Bit-serial M-bit subtractor: D = A - B - BIN (mod 2^M), computed LSB first
// as A + ~B + ~BIN through a single full adder, one bit per clock.
//   CLK   : clock (rising edge)
//   RST   : synchronous active-high reset
//   START : begin a subtraction (only honoured in IDLE)
//   A, B  : minuend / subtrahend, captured when START is accepted
//   BIN   : borrow-in, captured when START is accepted
//   D     : difference, valid from the DONE cycle until the next accepted START
//   BOUT  : borrow-out (1 = unsigned A < B + BIN)
//   OVF   : two's-complement overflow
//   BUSY  : high for the M cycles spent processing bits
//   DONE  : one-cycle pulse marking D/BOUT/OVF valid
module serial_subtractor_m_bits
  import serial_subtractor_m_bits_pkg::*;
#(
  parameter int unsigned M = HW2_DEFAULT_M
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [M-1:0] A,
  input  logic [M-1:0] B,
  input  logic         BIN,
  output logic [M-1:0] D,
  output logic         BOUT,
  output logic         OVF,
  output logic         BUSY,
  output logic         DONE
);

  localparam int unsigned CW = $clog2(M);
  localparam logic [CW-1:0] LAST = CW'(M - 1);

  hw2_state_e    state;
  logic [CW-1:0] cnt;
  logic [M-1:0]  a_sr;
  logic [M-1:0]  b_sr;     // holds ~B so the adder performs subtraction
  logic          carry;    // inverted borrow between bit slices
  logic          fa_s;
  logic          fa_cout;

  Vr_HW2_FA u_fa (
    .A    (a_sr[0]),
    .B    (b_sr[0]),
    .CIN  (carry),
    .S    (fa_s),
    .COUT (fa_cout)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      D     <= '0;
      BOUT  <= 1'b0;
      OVF   <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            a_sr  <= A;
            b_sr  <= ~B;
            carry <= ~BIN;
            cnt   <= '0;
            BUSY  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          // Sum bits enter at the top, so after M shifts bit 0 sits at D[0].
          D     <= {fa_s, D[M-1:1]};
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= fa_cout;
          if (cnt == LAST) begin
            // carry still holds the carry into the MSB slice here.
            BOUT  <= ~fa_cout;
            OVF   <= carry ^ fa_cout;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= FIN;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        FIN: begin
          DONE  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_m_bits.sv
module tb_serial_subtractor_m_bits;

  localparam int unsigned M = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         START = 1'b0;
  logic [M-1:0] A = '0;
  logic [M-1:0] B = '0;
  logic         BIN = 1'b0;
  logic [M-1:0] D;
  logic         BOUT;
  logic         OVF;
  logic         BUSY;
  logic         DONE;

  int tests = 0;
  int fails = 0;

  serial_subtractor_m_bits #(.M(M)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .A     (A),
    .B     (B),
    .BIN   (BIN),
    .D     (D),
    .BOUT  (BOUT),
    .OVF   (OVF),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bout;
    logic       ovf;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Accept one operation and follow it through to its DONE pulse.
  task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic bin, input logic [7:0] ed, input logic eb, input logic eo);
    int cyc;
    int busy_cnt;
    START = 1'b1; A = a; B = b; BIN = bin;
    tick();
    START = 1'b0;
    A = ~a; B = ~b; BIN = ~bin;   // operand changes during RUN must not matter
    cyc = 0;
    busy_cnt = 0;
    while (!DONE && cyc < 20) begin
      if (BUSY) busy_cnt++;
      tick();
      cyc++;
    end
    check({name, " latency"}, 32'(cyc), 32'(M));
    check({name, " busy cycles"}, 32'(busy_cnt), 32'(M));
    check({name, " D"}, 32'(D), 32'(ed));
    check({name, " BOUT"}, 32'(BOUT), 32'(eb));
    check({name, " OVF"}, 32'(OVF), 32'(eo));
    check({name, " BUSY at DONE"}, 32'(BUSY), 32'd0);
    tick();
    check({name, " DONE one cycle"}, 32'(DONE), 32'd0);
    check({name, " D hold"}, 32'(D), 32'(ed));
  endtask

  initial begin
    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[7] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[8] = '{8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1};
    vecs[9] = '{8'h3C, 8'h5A, 1'b0, 8'hE2, 1'b1, 1'b0};

    // Reset state
    RST = 1'b1;
    tick();
    tick();
    check("reset D", 32'(D), 32'd0);
    check("reset BOUT", 32'(BOUT), 32'd0);
    check("reset OVF", 32'(OVF), 32'd0);
    check("reset BUSY", 32'(BUSY), 32'd0);
    check("reset DONE", 32'(DONE), 32'd0);
    RST = 1'b0;
    tick();
    check("idle without START", 32'(BUSY), 32'd0);

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin,
             vecs[i].d, vecs[i].bout, vecs[i].ovf);
    end

    // START re-pulsed during RUN is ignored, only one DONE.
    begin
      int dones;
      START = 1'b1; A = 8'h05; B = 8'h03; BIN = 1'b0;
      tick();
      START = 1'b0;
      tick(); tick();
      START = 1'b1; A = 8'h40; B = 8'h01; BIN = 1'b1;
      tick();
      START = 1'b0;
      dones = 0;
      for (int i = 0; i < 20; i++) begin
        if (DONE) begin
          dones++;
          check("restart D", 32'(D), 32'h02);
        end
        tick();
      end
      check("restart done count", 32'(dones), 32'd1);
    end

    // Reset in RUN cycle 4 aborts without DONE.
    begin
      int dones;
      START = 1'b1; A = 8'h55; B = 8'h11; BIN = 1'b0;
      tick();
      START = 1'b0;
      tick(); tick(); tick();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      check("abort D", 32'(D), 32'd0);
      check("abort BOUT", 32'(BOUT), 32'd0);
      check("abort OVF", 32'(OVF), 32'd0);
      check("abort BUSY", 32'(BUSY), 32'd0);
      check("abort DONE", 32'(DONE), 32'd0);
      dones = 0;
      for (int i = 0; i < 12; i++) begin
        if (DONE || BUSY) dones++;
        tick();
      end
      check("abort no activity", 32'(dones), 32'd0);
      run_op("post-reset", 8'h55, 8'h11, 1'b0, 8'h44, 1'b0, 1'b0);
    end

    // START held high: one result every M+2 cycles.
    begin
      int n;
      int last;
      n = 0;
      last = -1;
      START = 1'b1; A = 8'h23; B = 8'h45; BIN = 1'b0;
      for (int i = 0; i < 30; i++) begin
        tick();
        if (DONE) begin
          check("b2b D", 32'(D), 32'hDE);
          check("b2b BOUT", 32'(BOUT), 32'd1);
          check("b2b OVF", 32'(OVF), 32'd0);
          if (last >= 0) check("b2b spacing", 32'(i - last), 32'(M + 2));
          else check("b2b first latency", 32'(i), 32'(M));
          last = i;
          n++;
        end
      end
      START = 1'b0;
      check("b2b done count", 32'(n), 32'd3);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
